exc_ack_sequencer: RTL and testbench
====================================

Name: exc_ack_sequencer

Overview:
- Responder side of the exception request/acknowledge handshake; sits in the core controller, opposite the exception controller that raises requests.
- Accepts exception/interrupt requests and ERET returns once the pipeline is safe: no outstanding LSU transfer, no jump resolving in ID, no debug halt.
- On acceptance it acks the requester and redirects the IF stage. It then squashes IF/ID for a fixed number of bubble cycles.

Parameters:
- FLUSH_CYCLES, 2, number of cycles `flush_o` stays high after a redirect; legal range 1..15.
- DRAIN_TIMEOUT, 15, DRAIN-state cycle count that sets `drain_timeout_o`; legal range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- exc_req_i  in  1  exception request; held by the requester until acked
- exc_ack_o  out  1  acknowledge; single-cycle pulse
- exc_pc_mux_i  in  2  exception vector select from the requester
- vec_pc_mux_i  in  5  vectored IRQ index from the requester
- eret_insn_i  in  1  ERET decoded in ID
- id_valid_i  in  1  ID stage holds a valid instruction
- data_req_pending_i  in  1  LSU transaction outstanding
- jump_in_id_i  in  1  branch/jump resolving in ID
- dbg_halt_i  in  1  debug unit halts the core
- pc_set_o  out  1  IF redirect strobe
- pc_mux_o  out  3  IF target select: 3'd0 none, 3'd4 exception, 3'd5 ERET
- exc_pc_mux_o  out  2  forwarded exception vector select
- vec_pc_mux_o  out  5  forwarded vectored IRQ index
- save_epc_o  out  1  CSR strobe: capture EPC and cause
- clear_ie_o  out  1  CSR strobe: clear interrupt enable on exception entry
- restore_ie_o  out  1  CSR strobe: restore interrupt enable on ERET
- flush_o  out  1  kill IF/ID contents
- busy_o  out  1  state is not IDLE
- drain_timeout_o  out  1  sticky drain-overrun flag

Behaviour:
- Reset: state = IDLE, both counters = 0. All outputs are 0 during and after reset.
- Reset mid-operation (any state): return to IDLE. No ack or strobe is issued for the in-flight request.
- Safe condition: `safe = !data_req_pending_i && !jump_in_id_i && !dbg_halt_i`.
- Accept actions (all combinational, in one cycle):
  - `exc_ack_o`, `pc_set_o`, `save_epc_o`, `clear_ie_o` = 1.
  - `pc_mux_o = 3'd4`.
  - `exc_pc_mux_o = exc_pc_mux_i`, `vec_pc_mux_o = vec_pc_mux_i`.
  - Load the flush counter with FLUSH_CYCLES; next state = FLUSH.
  - `exc_pc_mux_o` and `vec_pc_mux_o` are 0 in every cycle without `pc_set_o`.
- State IDLE:
  - `exc_req_i && safe`: accept in the same cycle (zero-latency ack).
  - `exc_req_i && !safe`: next state = DRAIN, drain counter cleared. No ack.
  - Otherwise, `eret_insn_i && id_valid_i && !dbg_halt_i && !data_req_pending_i`:
    - `pc_set_o = 1`, `pc_mux_o = 3'd5`, `restore_ie_o = 1`.
    - Load the flush counter; next state = FLUSH.
  - A request outranks a simultaneous ERET. The ERET is replayed by the pipeline later; it is not remembered here.
- State DRAIN:
  - `busy_o = 1`; the drain counter increments each cycle, saturating.
  - When the counter reaches DRAIN_TIMEOUT, set `drain_timeout_o`. It stays set until reset; the block keeps waiting.
  - When `safe` and `exc_req_i`: accept, next state = FLUSH.
  - If `exc_req_i` drops (requester reset or protocol error): return to IDLE, no ack.
- State FLUSH:
  - `flush_o = 1`, `busy_o = 1`; the flush counter decrements each cycle.
  - Return to IDLE in the cycle after the counter reads 1, so `flush_o` is high for exactly FLUSH_CYCLES cycles.
  - `exc_req_i` and `eret_insn_i` are ignored: no ack. A held request is accepted in IDLE afterwards.
- Width rules: the drain counter is wide enough to hold DRAIN_TIMEOUT; the flush counter is 4 bits. Both saturate and never wrap.
- Handshake invariants (assert in verification):
  - `exc_ack_o` implies `exc_req_i`.
  - `exc_ack_o` implies `pc_set_o`.
  - At most one ack per request assertion.
  - `exc_ack_o` is never high in FLUSH.

Test Plan:
- Idle accept: pulse `exc_req_i=1`, `exc_pc_mux_i=2'd2`, `vec_pc_mux_i=5'd7` with safe=1 → same cycle:
  - `exc_ack_o=1`, `pc_set_o=1`, `pc_mux_o=3'd4`, `exc_pc_mux_o=2`, `vec_pc_mux_o=7`, `save_epc_o=1`, `clear_ie_o=1`.
  - Then `flush_o=1` for 2 cycles, then `busy_o=0`.
- Drain: `exc_req_i=1` held with `data_req_pending_i=1` for 5 cycles → `exc_ack_o=0` throughout; ack in the cycle pending drops; `drain_timeout_o=0`.
- Timeout: `jump_in_id_i=1` held for 20 cycles with request held → `drain_timeout_o` rises after 15 DRAIN cycles and stays 1; ack arrives when the jump clears.
- ERET: `eret_insn_i=1`, `id_valid_i=1` → `pc_set_o=1`, `pc_mux_o=3'd5`, `restore_ie_o=1`, `exc_ack_o=0`, 2 flush cycles.
  - Same cycle as `exc_req_i` → the exception wins (`pc_mux_o=3'd4`, no `restore_ie_o`).
- Request during FLUSH: raise `exc_req_i` one cycle after an accept and hold it → no ack during the 2 flush cycles; ack in the first IDLE cycle.
- Reset in DRAIN: assert `rst_n=0` while in DRAIN → all outputs 0 immediately, state IDLE, `drain_timeout_o=0`, no ack.

Source files
------------

// File: rtl/exc_ack_sequencer.sv
// rtl/exc_ack_sequencer.sv - exception request/ack responder with drain and flush sequencing
module exc_ack_sequencer #(
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       exc_req_i,
    output logic       exc_ack_o,
    input  logic [1:0] exc_pc_mux_i,
    input  logic [4:0] vec_pc_mux_i,
    input  logic       eret_insn_i,
    input  logic       id_valid_i,
    input  logic       data_req_pending_i,
    input  logic       jump_in_id_i,
    input  logic       dbg_halt_i,
    output logic       pc_set_o,
    output logic [2:0] pc_mux_o,
    output logic [1:0] exc_pc_mux_o,
    output logic [4:0] vec_pc_mux_o,
    output logic       save_epc_o,
    output logic       clear_ie_o,
    output logic       restore_ie_o,
    output logic       flush_o,
    output logic       busy_o,
    output logic       drain_timeout_o
);

    localparam int unsigned     DW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DW-1:0]   DRAIN_MAX  = DW'(DRAIN_TIMEOUT);
    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [3:0]    flush_cnt_q, flush_cnt_d;
    logic          timeout_q, timeout_d;
    logic          safe, accept, eret_take;

    assign safe = !data_req_pending_i && !jump_in_id_i && !dbg_halt_i;

    // Combinational strobes are gated by rst_n so nothing escapes while reset is held.
    assign accept    = rst_n && exc_req_i && safe && (state_q == IDLE || state_q == DRAIN);
    assign eret_take = rst_n && (state_q == IDLE) && !exc_req_i && eret_insn_i && id_valid_i
                       && !dbg_halt_i && !data_req_pending_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            flush_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (accept || eret_take) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (exc_req_i) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q != DRAIN_MAX) drain_cnt_d = drain_cnt_q + 1'b1;
                // Flag rises on the edge the counter lands on the limit; the block keeps waiting.
                if (drain_cnt_d == DRAIN_MAX) timeout_d = 1'b1;
                if (accept) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end else if (!exc_req_i) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_q != 4'd0) flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        exc_ack_o       = accept;
        pc_set_o        = accept || eret_take;
        pc_mux_o        = accept ? 3'd4 : (eret_take ? 3'd5 : 3'd0);
        exc_pc_mux_o    = accept ? exc_pc_mux_i : 2'd0;
        vec_pc_mux_o    = accept ? vec_pc_mux_i : 5'd0;
        save_epc_o      = accept;
        clear_ie_o      = accept;
        restore_ie_o    = eret_take;
        flush_o         = (state_q == FLUSH);
        busy_o          = (state_q != IDLE);
        drain_timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_exc_ack_sequencer.sv
// tb/tb_exc_ack_sequencer.sv - scoreboard bench for exc_ack_sequencer
module tb_exc_ack_sequencer;

    logic       clk, rst_n;
    logic       exc_req_i, exc_ack_o;
    logic [1:0] exc_pc_mux_i, exc_pc_mux_o;
    logic [4:0] vec_pc_mux_i, vec_pc_mux_o;
    logic       eret_insn_i, id_valid_i, data_req_pending_i, jump_in_id_i, dbg_halt_i;
    logic       pc_set_o, save_epc_o, clear_ie_o, restore_ie_o, flush_o, busy_o, drain_timeout_o;
    logic [2:0] pc_mux_o;

    exc_ack_sequencer #(.FLUSH_CYCLES(2), .DRAIN_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req_i(exc_req_i), .exc_ack_o(exc_ack_o),
        .exc_pc_mux_i(exc_pc_mux_i), .vec_pc_mux_i(vec_pc_mux_i),
        .eret_insn_i(eret_insn_i), .id_valid_i(id_valid_i),
        .data_req_pending_i(data_req_pending_i), .jump_in_id_i(jump_in_id_i),
        .dbg_halt_i(dbg_halt_i),
        .pc_set_o(pc_set_o), .pc_mux_o(pc_mux_o),
        .exc_pc_mux_o(exc_pc_mux_o), .vec_pc_mux_o(vec_pc_mux_o),
        .save_epc_o(save_epc_o), .clear_ie_o(clear_ie_o), .restore_ie_o(restore_ie_o),
        .flush_o(flush_o), .busy_o(busy_o), .drain_timeout_o(drain_timeout_o)
    );

    typedef struct packed {
        logic       ack;
        logic       pc_set;
        logic [2:0] pc_mux;
        logic [1:0] epc;
        logic [4:0] vec;
        logic       save;
        logic       clr;
        logic       rest;
        logic       flush;
        logic       busy;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic acked = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t f_idle(input logic to);
        exp_t e = '0;
        e.to = to;
        return e;
    endfunction

    function automatic exp_t f_drain(input logic to);
        exp_t e = '0;
        e.busy = 1'b1;
        e.to   = to;
        return e;
    endfunction

    function automatic exp_t f_flush(input logic to);
        exp_t e = '0;
        e.flush = 1'b1;
        e.busy  = 1'b1;
        e.to    = to;
        return e;
    endfunction

    function automatic exp_t f_accept(input logic [1:0] epc, input logic [4:0] vec,
                                      input logic busy, input logic to);
        exp_t e = '0;
        e.ack = 1'b1; e.pc_set = 1'b1; e.pc_mux = 3'd4;
        e.epc = epc;  e.vec = vec;     e.save = 1'b1; e.clr = 1'b1;
        e.busy = busy; e.to = to;
        return e;
    endfunction

    function automatic exp_t f_eret();
        exp_t e = '0;
        e.pc_set = 1'b1; e.pc_mux = 3'd5; e.rest = 1'b1;
        return e;
    endfunction

    // Expectation is queued when the inputs are applied and retired at the next sampling point.
    task automatic step(input string tag, input exp_t e);
        exp_t obs;
        exp_q.push_back(e);
        @(negedge clk);
        obs = {exc_ack_o, pc_set_o, pc_mux_o, exc_pc_mux_o, vec_pc_mux_o,
               save_epc_o, clear_ie_o, restore_ie_o, flush_o, busy_o, drain_timeout_o};
        check_eq(tag, 32'(obs), 32'(exp_q.pop_front()));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("inv_ack_req",   32'(exc_ack_o & ~exc_req_i), 32'd0);
            check_eq("inv_ack_pcset", 32'(exc_ack_o & ~pc_set_o), 32'd0);
            check_eq("inv_ack_flush", 32'(exc_ack_o & flush_o), 32'd0);
            check_eq("inv_one_ack",   32'(exc_ack_o & acked), 32'd0);
        end
        if (!rst_n || !exc_req_i) acked = 1'b0;
        else if (exc_ack_o)       acked = 1'b1;
    end

    initial begin
        rst_n = 1'b0; exc_req_i = 1'b1; exc_pc_mux_i = 2'd0; vec_pc_mux_i = 5'd0;
        eret_insn_i = 1'b0; id_valid_i = 1'b0; data_req_pending_i = 1'b0;
        jump_in_id_i = 1'b0; dbg_halt_i = 1'b0;
        @(posedge clk); #1;
        step("in_reset", f_idle(1'b0));
        exc_req_i = 1'b0; rst_n = 1'b1;
        step("after_reset", f_idle(1'b0));

        exc_req_i = 1'b1; exc_pc_mux_i = 2'd2; vec_pc_mux_i = 5'd7;
        step("idle_accept", f_accept(2'd2, 5'd7, 1'b0, 1'b0));
        exc_req_i = 1'b0;
        step("idle_flush1", f_flush(1'b0));
        step("idle_flush2", f_flush(1'b0));
        step("idle_done", f_idle(1'b0));

        exc_req_i = 1'b1; data_req_pending_i = 1'b1; exc_pc_mux_i = 2'd1; vec_pc_mux_i = 5'd4;
        step("drain_enter", f_idle(1'b0));
        for (int i = 0; i < 4; i++) step("drain_wait", f_drain(1'b0));
        data_req_pending_i = 1'b0;
        step("drain_accept", f_accept(2'd1, 5'd4, 1'b1, 1'b0));
        exc_req_i = 1'b0;
        step("drain_flush1", f_flush(1'b0));
        step("drain_flush2", f_flush(1'b0));
        step("drain_done", f_idle(1'b0));

        exc_req_i = 1'b1; jump_in_id_i = 1'b1; exc_pc_mux_i = 2'd3; vec_pc_mux_i = 5'd9;
        step("to_enter", f_idle(1'b0));
        for (int k = 1; k <= 19; k++) step(k <= 15 ? "to_wait_low" : "to_wait_high", f_drain(k > 15));
        jump_in_id_i = 1'b0;
        step("to_accept", f_accept(2'd3, 5'd9, 1'b1, 1'b1));
        exc_req_i = 1'b0;
        step("to_flush1", f_flush(1'b1));
        step("to_flush2", f_flush(1'b1));
        step("to_sticky", f_idle(1'b1));

        exc_req_i = 1'b1; data_req_pending_i = 1'b1;
        step("rst_enter", f_idle(1'b1));
        step("rst_drain", f_drain(1'b1));
        rst_n = 1'b0;
        step("rst_in_drain", f_idle(1'b0));
        exc_req_i = 1'b0; data_req_pending_i = 1'b0; rst_n = 1'b1;
        step("rst_release", f_idle(1'b0));

        eret_insn_i = 1'b1; id_valid_i = 1'b1; data_req_pending_i = 1'b1;
        step("eret_blocked", f_idle(1'b0));
        data_req_pending_i = 1'b0;
        step("eret_take", f_eret());
        eret_insn_i = 1'b0;
        step("eret_flush1", f_flush(1'b0));
        step("eret_flush2", f_flush(1'b0));
        step("eret_done", f_idle(1'b0));

        eret_insn_i = 1'b1; exc_req_i = 1'b1; exc_pc_mux_i = 2'd1; vec_pc_mux_i = 5'd3;
        step("eret_vs_req", f_accept(2'd1, 5'd3, 1'b0, 1'b0));
        eret_insn_i = 1'b0; exc_req_i = 1'b0;
        step("evr_flush1", f_flush(1'b0));
        step("evr_flush2", f_flush(1'b0));
        step("evr_done", f_idle(1'b0));

        exc_req_i = 1'b1; exc_pc_mux_i = 2'd3; vec_pc_mux_i = 5'd31;
        step("fr_accept", f_accept(2'd3, 5'd31, 1'b0, 1'b0));
        exc_req_i = 1'b0;
        step("fr_flush1", f_flush(1'b0));
        exc_req_i = 1'b1; exc_pc_mux_i = 2'd0; vec_pc_mux_i = 5'd1;
        eret_insn_i = 1'b1; id_valid_i = 1'b1;
        step("fr_flush2_held", f_flush(1'b0));
        eret_insn_i = 1'b0;
        step("fr_idle_accept", f_accept(2'd0, 5'd1, 1'b0, 1'b0));
        exc_req_i = 1'b0;
        step("fr2_flush1", f_flush(1'b0));
        step("fr2_flush2", f_flush(1'b0));
        step("fr2_done", f_idle(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
